seq_bin2bcd: RTL and testbench
==============================

Name: seq_bin2bcd

Overview:
- Iterative binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Each iteration applies the add-3 correction to every BCD digit above 4, then shifts one bit in.
- Generalises the timer's single-digit combinational add-3 cell to any binary width and digit count, with a start/busy/done handshake.
- Sits between the timer counters and the seven-segment digit drivers, so wide counts are converted in one shared sequential unit.

Parameters:
- BIN_WIDTH, 8, width of the unsigned binary input (>= 1).
- DIGITS, 3, number of BCD output digits (>= 1); the output is 4*DIGITS bits wide.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin_in  input  BIN_WIDTH  unsigned value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out is updated.
- bcd_out  output  4*DIGITS  result; digit 0 in bits [3:0]; holds its value between conversions.
- overflow  output  1  result did not fit in DIGITS digits; valid with done, held with bcd_out.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, bcd_out=0, overflow=0; scratch registers and counter cleared.
- Reset has priority over every other event. Reset mid-conversion aborts it: no done pulse, bcd_out is zeroed.
- FSM states: IDLE, ADJUST, SHIFT.
- IDLE, start=1 on an edge:
  - load the shift register with bin_in and the BCD scratch with 0;
  - clear the overflow scratch; bit counter = BIN_WIDTH;
  - go to ADJUST; busy=1 from the next cycle.
- IDLE, start=0: stay in IDLE.
- ADJUST: each scratch digit d is replaced by d+3 (4-bit) if d>4, otherwise left unchanged. All digits are adjusted in parallel. Go to SHIFT.
- SHIFT:
  - shift {scratch, shift register} left by 1;
  - the MSB leaving the top digit ORs into the overflow scratch;
  - counter decrements.
- SHIFT, counter reaches 0 on this edge:
  - bcd_out <= post-shift scratch; overflow <= overflow scratch;
  - done=1 for the following cycle only; busy=0 in that cycle;
  - go to IDLE.
- SHIFT, counter nonzero: go to ADJUST.
- Latency: done is high in the cycle after the 2*BIN_WIDTH-th rising edge following the edge that sampled start. Example: 16 edges for BIN_WIDTH=8.
- busy pattern: high for exactly 2*BIN_WIDTH cycles per conversion, never high together with done.
- start while busy=1: ignored; does not restart, does not queue.
- start high during the done cycle: accepted, since the FSM is in IDLE. Back-to-back conversions have no gap cycle.
- start held high continuously: a new conversion starts in each done cycle.
- bin_in changes after acceptance have no effect on the current conversion.
- overflow: when DIGITS >= ceil(BIN_WIDTH*log10(2)), overflow is always 0. Otherwise bcd_out holds the low DIGITS decimal digits, i.e. value mod 10^DIGITS, and overflow=1 iff value >= 10^DIGITS.
- Arithmetic: all digit arithmetic is 4-bit unsigned. After adjust, no digit carries into its neighbour; carries move only through the shift.

Test Plan:
- BIN_WIDTH=8, DIGITS=3; reset, then start with bin_in=0 -> done after exactly 16 edges, bcd_out=12'h000, overflow=0; busy high for 16 cycles.
- Same config, exhaustive sweep 0..255 using back-to-back starts (start held high) -> every result equals the decimal digits of the input (e.g. 255 -> 12'h255, 99 -> 12'h099, 100 -> 12'h100). One done per conversion, no idle gap.
- Same config, start with 200; pulse start again with 37 at cycle 5 while busy -> result 12'h200; the second start is ignored, with only one done pulse.
- Same config, start with 173; assert reset at cycle 9 -> next cycle busy=0, bcd_out=0, no done pulse. A following start with 42 -> 12'h042.
- BIN_WIDTH=8, DIGITS=2; inputs 99 and 255 -> 8'h99 with overflow=0, then 8'h55 with overflow=1.
- BIN_WIDTH=16, DIGITS=5; input 65535 -> 20'h65535 after 32 edges; input 10000 -> 20'h10000, overflow=0.

Source files
------------

// File: rtl/seq_bin2bcd.sv
// seq_bin2bcd: iterative double-dabble converter; start/bin_in in, busy/done/bcd_out/overflow out
module seq_bin2bcd #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, ADJUST, SHIFT} state_t;
  state_t state_q, state_d;
  logic [BIN_WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0] scr_q, scr_d, adj, shifted, bcd_q, bcd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, busy_q, busy_d, done_q, done_d, overflow_q, overflow_d;
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = scr_q[4*i +: 4] > 4'd4 ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
  end
  assign shifted = {scr_q[BW-2:0], sh_q[BIN_WIDTH-1]};
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    scr_d = scr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    busy_d = busy_q;
    done_d = 1'b0;
    bcd_d = bcd_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: if (start) begin
        sh_d = bin_in;
        scr_d = '0;
        ovf_d = 1'b0;
        cnt_d = CW'(BIN_WIDTH);
        busy_d = 1'b1;
        state_d = ADJUST;
      end
      ADJUST: begin
        scr_d = adj;
        state_d = SHIFT;
      end
      SHIFT: begin
        scr_d = shifted;
        sh_d = sh_q << 1;
        ovf_d = ovf_q | scr_q[BW-1];
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? IDLE : ADJUST;
        if (cnt_q == CW'(1)) begin
          bcd_d = shifted;
          overflow_d = ovf_q | scr_q[BW-1];
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      scr_q <= scr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bcd_q <= bcd_d;
      overflow_q <= overflow_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign bcd_out = bcd_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_seq_bin2bcd.sv
// tb_seq_bin2bcd: random and directed checks of seq_bin2bcd against an arithmetic model
module tb_seq_bin2bcd;
  logic clk = 0, reset = 1;
  logic start_a = 0, start_b = 0, start_c = 0;
  logic [7:0] bin_a = 0, bin_b = 0;
  logic [15:0] bin_c = 0;
  logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b, busy_c, done_c, ovf_c;
  logic [11:0] bcd_a;
  logic [7:0] bcd_b;
  logic [19:0] bcd_c;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  seq_bin2bcd #(.BIN_WIDTH(8), .DIGITS(3)) dut_a (.clk(clk), .reset(reset), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a));
  seq_bin2bcd #(.BIN_WIDTH(8), .DIGITS(2)) dut_b (.clk(clk), .reset(reset), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b));
  seq_bin2bcd #(.BIN_WIDTH(16), .DIGITS(5)) dut_c (.clk(clk), .reset(reset), .start(start_c), .bin_in(bin_c),
    .busy(busy_c), .done(done_c), .bcd_out(bcd_c), .overflow(ovf_c));
  function automatic logic [19:0] dec(int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  int rem = 0, m_val = 0;
  logic [11:0] m_bcd = 0;
  logic m_ovf = 0, m_done = 0, m_live = 0;
  always @(posedge clk) begin
    m_done = 0;
    if (reset) begin
      rem = 0;
      m_bcd = 0;
      m_ovf = 0;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        m_done = 1;
        m_bcd = 12'(dec(m_val % 1000));
        m_ovf = m_val >= 1000;
      end
    end else if (start_a) begin
      m_val = int'(bin_a);
      rem = 16;
    end
    m_live = 1;
  end
  always @(negedge clk) if (m_live) begin
    chk("a_busy", 32'(busy_a), 32'(rem > 0));
    chk("a_done", 32'(done_a), 32'(m_done));
    chk("a_bcd", 32'(bcd_a), 32'(m_bcd));
    chk("a_ovf", 32'(ovf_a), 32'(m_ovf));
  end
  task automatic run(input int w, input int v, input bit hold, output int cyc, output int nb);
    bit d;
    cyc = 0;
    nb = 0;
    d = 0;
    if (w == 0) begin bin_a = 8'(v); start_a = 1; end
    else if (w == 1) begin bin_b = 8'(v); start_b = 1; end
    else begin bin_c = 16'(v); start_c = 1; end
    while (!d && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !hold) begin start_a = 0; start_b = 0; start_c = 0; end
      d = w == 0 ? done_a : w == 1 ? done_b : done_c;
      nb += int'(w == 0 ? busy_a : w == 1 ? busy_b : busy_c);
    end
    if (!d) chk("done_timeout", 32'(cyc), 32'(0));
  endtask
  initial begin
    int cyc, nb, v, nd;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_bcd", 32'(bcd_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    reset = 0;
    @(negedge clk);
    run(0, 0, 0, cyc, nb);
    chk("zero_latency", 32'(cyc), 17);
    chk("zero_busy_cycles", 32'(nb), 16);
    chk("zero_bcd", 32'(bcd_a), 32'h000);
    chk("zero_ovf", 32'(ovf_a), 0);
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      run(0, i, 1, cyc, nb);
      chk("sweep_latency", 32'(cyc), 17);
      chk("sweep_busy_cycles", 32'(nb), 16);
      if (i == 99) chk("sweep_99", 32'(bcd_a), 32'h099);
      if (i == 100) chk("sweep_100", 32'(bcd_a), 32'h100);
      if (i == 255) chk("sweep_255", 32'(bcd_a), 32'h255);
    end
    start_a = 0;
    repeat (3) @(negedge clk);
    bin_a = 200;
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    repeat (3) @(negedge clk);
    bin_a = 37;
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    cyc = 0;
    while (!done_a && cyc < 40) begin @(negedge clk); cyc++; end
    chk("ignore_restart_bcd", 32'(bcd_a), 32'h200);
    nd = 0;
    repeat (30) begin @(negedge clk); nd += int'(done_a); end
    chk("ignore_restart_single_done", 32'(nd), 0);
    bin_a = 173;
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    repeat (8) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort_busy", 32'(busy_a), 0);
    chk("abort_bcd", 32'(bcd_a), 0);
    nd = 0;
    repeat (20) begin @(negedge clk); nd += int'(done_a); end
    chk("abort_no_done", 32'(nd), 0);
    run(0, 42, 0, cyc, nb);
    chk("after_abort_42", 32'(bcd_a), 32'h042);
    run(1, 99, 0, cyc, nb);
    chk("d2_99_bcd", 32'(bcd_b), 32'h99);
    chk("d2_99_ovf", 32'(ovf_b), 0);
    run(1, 255, 0, cyc, nb);
    chk("d2_255_bcd", 32'(bcd_b), 32'h55);
    chk("d2_255_ovf", 32'(ovf_b), 1);
    repeat (12) begin
      v = int'($urandom_range(0, 255));
      run(1, v, 0, cyc, nb);
      chk("d2_rand_bcd", 32'(bcd_b), 32'(dec(v % 100)));
      chk("d2_rand_ovf", 32'(ovf_b), 32'(v >= 100));
    end
    run(2, 65535, 0, cyc, nb);
    chk("w16_latency", 32'(cyc), 33);
    chk("w16_busy_cycles", 32'(nb), 32);
    chk("w16_65535", 32'(bcd_c), 32'h65535);
    chk("w16_65535_ovf", 32'(ovf_c), 0);
    run(2, 10000, 0, cyc, nb);
    chk("w16_10000", 32'(bcd_c), 32'h10000);
    chk("w16_10000_ovf", 32'(ovf_c), 0);
    repeat (8) begin
      v = int'($urandom_range(0, 65535));
      run(2, v, 0, cyc, nb);
      chk("w16_rand", 32'(bcd_c), 32'(dec(v)));
    end
    repeat (1500) begin
      @(negedge clk);
      reset = $urandom_range(0, 199) == 0;
      start_a = $urandom_range(0, 3) == 0;
      bin_a = 8'($urandom);
    end
    reset = 0;
    start_a = 0;
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
